// File: rtl/tradeoff_pkg.sv
// Shared definitions for the Tradeoff request controller and the Tradeoff search engine.
package tradeoff_pkg;

    localparam int TRADEOFF_W_BITS      = 30;
    localparam int TRADEOFF_N_BITS      = 17;
    localparam int TRADEOFF_TIMEOUT_CYC = 140000;
    localparam int DONE_CNT_BITS        = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        CAPT,
        DONE
    } state_t;

    // Bits needed to hold the values 0 .. n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tradeoff_sat_cnt.sv
// Up-counter with synchronous clear that stops at MAX_VAL and flags it.
module tradeoff_sat_cnt
    import tradeoff_pkg::*;
#(
    parameter int               WIDTH   = DONE_CNT_BITS,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign cnt = cnt_q;
    assign sat = (cnt_q == MAX_VAL);

    // Clear wins over enable; a saturated counter holds until cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !sat) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tradeoff_req_ctrl.sv
// Request controller: hands one word to the Tradeoff engine, waits for a fresh found
// (or a timeout), and holds the result until the consumer takes it.
module tradeoff_req_ctrl
    import tradeoff_pkg::*;
#(
    parameter int W_BITS      = TRADEOFF_W_BITS,
    parameter int N_BITS      = TRADEOFF_N_BITS,
    parameter int TIMEOUT_CYC = TRADEOFF_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W_BITS-1:0]        in_w,
    output logic [W_BITS-1:0]        eng_w,
    input  logic                     eng_found,
    input  logic [N_BITS-1:0]        eng_n,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W_BITS-1:0]        out_w,
    output logic [N_BITS-1:0]        out_n,
    output logic                     out_timeout,
    output logic [DONE_CNT_BITS-1:0] done_cnt
);

    localparam int              TO_W    = cnt_width(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic                live_q, live_d;
    logic [W_BITS-1:0]   eng_w_q, eng_w_d;
    logic [W_BITS-1:0]   out_w_q, out_w_d;
    logic [N_BITS-1:0]   out_n_q, out_n_d;
    logic                out_to_q, out_to_d;

    logic                accept;
    logic                to_clr;
    logic                to_en;
    logic                to_hit;
    logic                done_en;
    logic [TO_W-1:0]     unused_to_cnt;
    logic                unused_done_sat;

    // The timeout counter stops at TIMEOUT_CYC-1, so its saturate flag is the timeout.
    tradeoff_sat_cnt #(
        .WIDTH   (TO_W),
        .MAX_VAL (TO_LAST)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (to_clr),
        .en    (to_en),
        .cnt   (unused_to_cnt),
        .sat   (to_hit)
    );

    tradeoff_sat_cnt #(
        .WIDTH   (DONE_CNT_BITS),
        .MAX_VAL ({DONE_CNT_BITS{1'b1}})
    ) u_done_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (done_en),
        .cnt   (done_cnt),
        .sat   (unused_done_sat)
    );

    // live_q keeps in_ready low until the first edge after reset is released.
    assign live_d      = 1'b1;
    assign in_ready    = live_q && (state_q == IDLE);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == DONE);
    assign eng_w       = eng_w_q;
    assign out_w       = out_w_q;
    assign out_n       = out_n_q;
    assign out_timeout = out_to_q;

    always_comb begin
        state_d  = state_q;
        eng_w_d  = eng_w_q;
        out_w_d  = out_w_q;
        out_n_d  = out_n_q;
        out_to_d = out_to_q;
        to_clr   = 1'b0;
        to_en    = 1'b0;
        done_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    eng_w_d = in_w;
                    out_w_d = in_w;
                    to_clr  = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                to_en = 1'b1;
                if (to_hit) begin
                    out_n_d  = '0;
                    out_to_d = 1'b1;
                    state_d  = DONE;
                end else if (!eng_found) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                to_en = 1'b1;
                if (to_hit) begin
                    out_n_d  = '0;
                    out_to_d = 1'b1;
                    state_d  = DONE;
                end else if (eng_found) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                out_n_d  = eng_n;
                out_to_d = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    done_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            eng_w_q  <= '0;
            out_w_q  <= '0;
            out_n_q  <= '0;
            out_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            live_q   <= live_d;
            eng_w_q  <= eng_w_d;
            out_w_q  <= out_w_d;
            out_n_q  <= out_n_d;
            out_to_q <= out_to_d;
        end
    end

endmodule
